// File: rtl/alu_shift_pkg.sv
// Shared encodings for the sequential shift/rotate unit.
package alu_shift_pkg;

  typedef enum logic [2:0] {
    OP_ROL  = 3'd0,
    OP_ROR  = 3'd1,
    OP_SHL  = 3'd2,
    OP_SHR  = 3'd3,
    OP_SHRA = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single-step mover: shifts or rotates value by k (0..STEP) bits.
module alu_shift_step
  import alu_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4,
  localparam int unsigned KW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] value,
  input  logic [2:0]       op,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] moved_c
);

  logic [2*WIDTH-1:0] dbl;

  // Rotates use a doubled word so the wrapped bits fall out of one shift.
  always_comb begin
    moved_c = value;
    dbl     = '0;
    case (op)
      OP_ROL: begin
        dbl     = {value, value} << k;
        moved_c = dbl[2*WIDTH-1:WIDTH];
      end
      OP_ROR: begin
        dbl     = {value, value} >> k;
        moved_c = dbl[WIDTH-1:0];
      end
      OP_SHL:  moved_c = value << k;
      OP_SHR:  moved_c = value >> k;
      OP_SHRA: moved_c = WIDTH'($signed(value) >>> k);
      default: moved_c = value;
    endcase
  end

endmodule

// File: rtl/alu_shift_seq.sv
// Multi-cycle shift/rotate unit: moves the operand by up to STEP bits per cycle.
module alu_shift_seq
  import alu_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in,
  input  logic [CNT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  localparam int unsigned KW = $clog2(STEP + 1);

  state_e           state;
  logic [WIDTH-1:0] work;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] rem;
  logic [KW-1:0]    k_c;
  logic [WIDTH-1:0] moved_c;
  logic             legal_c;
  logic [CNT_W-1:0] amt_c;

  // Bits moved this cycle: min(STEP, remaining).
  always_comb begin
    k_c = KW'(rem);
    if (32'(rem) >= STEP) k_c = KW'(STEP);
  end

  // Illegal ops degrade to a zero-distance pass-through.
  always_comb begin
    legal_c = (op <= OP_SHRA);
    amt_c   = legal_c ? amount : '0;
  end

  alu_shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .value   (work),
    .op      (op_q),
    .k       (k_c),
    .moved_c (moved_c)
  );

  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      out   <= '0;
      work  <= '0;
      op_q  <= OP_ROL;
      rem   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            work <= in;
            op_q <= op;
            rem  <= amt_c;
            busy <= 1'b1;
            if (amt_c == '0) begin
              state <= DONE;
              done  <= 1'b1;
              out   <= in;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          work <= moved_c;
          rem  <= rem - CNT_W'(k_c);
          // Result and done are registered on the transition into DONE.
          if (rem == CNT_W'(k_c)) begin
            state <= DONE;
            done  <= 1'b1;
            out   <= moved_c;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Directed and randomized bench for alu_shift_seq (WIDTH=32, STEP=4) with a result scoreboard.
module tb_alu_shift_seq;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] din = 32'd0;
  logic [4:0]  amount = 5'd0;
  logic        busy;
  logic        done;
  logic [31:0] out;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_shift_seq #(.WIDTH(32), .STEP(4)) dut (
    .clk    (clk),
    .clr    (clr),
    .start  (start),
    .op     (op),
    .in     (din),
    .amount (amount),
    .busy   (busy),
    .done   (done),
    .out    (out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] v, input int a);
    case (o)
      3'd0:    return (a == 0) ? v : ((v << a) | (v >> (32 - a)));
      3'd1:    return (a == 0) ? v : ((v >> a) | (v << (32 - a)));
      3'd2:    return v << a;
      3'd3:    return v >> a;
      3'd4:    return 32'($signed(v) >>> a);
      default: return v;
    endcase
  endfunction

  // Issue one op, scramble inputs after the sample edge, wait for done, compare against the scoreboard.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] v,
                       input logic [4:0] a, input logic [31:0] eo, input int el, input bit glitch);
    exp_t e;
    int   lat;
    int   busy_n;
    int   extra;
    bit   got;
    exp_q.push_back('{eo, el});
    op = o; din = v; amount = a; start = 1'b1;
    tick();
    start = 1'b0;
    op = 3'($urandom_range(0, 7));
    din = $urandom;
    amount = 5'($urandom);
    lat = 1; busy_n = 0; got = 1'b0;
    while (!got && lat <= 40) begin
      if (busy) busy_n++;
      if (done) got = 1'b1;
      else begin
        if (glitch && lat == 2) begin
          start = 1'b1; op = 3'd0; din = 32'h0000_00FF; amount = 5'd3;
        end else begin
          start = 1'b0;
        end
        tick();
        lat++;
      end
    end
    start = 1'b0;
    check({tag, " done seen"}, 32'(got), 32'd1);
    e = exp_q.pop_front();
    check({tag, " out"}, out, e.res);
    check({tag, " latency"}, 32'(lat), 32'(e.lat));
    check({tag, " busy cycles"}, 32'(busy_n), 32'(e.lat));
    tick();
    check({tag, " done pulse width"}, 32'(done), 32'd0);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " out held"}, out, e.res);
    if (glitch) begin
      extra = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (done) extra++;
      end
      check({tag, " dropped request"}, 32'(extra), 32'd0);
    end
  endtask

  initial begin
    int extra;
    logic [2:0]  ro;
    logic [31:0] rv;
    logic [4:0]  ra;
    int          rl;

    clr = 1'b0;
    repeat (3) tick();
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset out", out, 32'd0);

    // start coincident with reset must be ignored
    start = 1'b1; op = 3'd0; din = 32'h5; amount = 5'd1;
    tick();
    start = 1'b0;
    clr = 1'b1;
    tick();
    check("start under reset", 32'(busy), 32'd0);
    tick();
    check("start under reset done", 32'(done), 32'd0);

    do_op("rol1",    3'd0, 32'h8000_0001, 5'd1,  32'h0000_0003, 2, 1'b0);
    do_op("ror4",    3'd1, 32'h0000_000F, 5'd4,  32'hF000_0000, 2, 1'b0);
    do_op("shl16",   3'd2, 32'hFFFF_FFFF, 5'd16, 32'hFFFF_0000, 5, 1'b0);
    do_op("shra31",  3'd4, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 9, 1'b0);
    do_op("shr31",   3'd3, 32'h8000_0000, 5'd31, 32'h0000_0001, 9, 1'b0);
    do_op("rol0",    3'd0, 32'h1234_5678, 5'd0,  32'h1234_5678, 1, 1'b0);
    do_op("illegal", 3'd6, 32'hDEAD_BEEF, 5'd7,  32'hDEAD_BEEF, 1, 1'b0);
    do_op("rol31",   3'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 9, 1'b1);
    do_op("shra5",   3'd4, 32'h7000_0000, 5'd5,  32'h0380_0000, 3, 1'b0);

    for (int i = 0; i < 10; i++) begin
      ro = 3'($urandom_range(0, 7));
      rv = $urandom;
      ra = 5'($urandom);
      rl = (ro > 3'd4 || ra == 5'd0) ? 1 : (int'(ra) + 3) / 4 + 1;
      do_op("rand", ro, rv, ra, model(ro, rv, (ro > 3'd4) ? 0 : int'(ra)), rl, 1'b0);
    end

    // abort SHL 20 in its third RUN cycle
    op = 3'd2; din = 32'hFFFF_FFFF; amount = 5'd20; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    clr = 1'b0;
    tick();
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort out", out, 32'd0);
    clr = 1'b1;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) extra++;
    end
    check("abort no done", 32'(extra), 32'd0);
    check("abort stays idle", 32'(busy), 32'd0);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
